// File: rtl/ram_bist.sv
// Built-in self-test initiator for a single-port synchronous RAM: writes an
// address+seed pattern to every word, reads it back, and counts mismatches.
module ram_bist #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int LAST_ADDR = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DATA_W-1:0] SEED,
    input  logic [DATA_W-1:0] Dout,
    output logic [DATA_W-1:0] Din,
    output logic [ADDR_W-1:0] Addr,
    output logic              EN,
    output logic              WE,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [ADDR_W:0]   ERR_CNT,
    output logic [ADDR_W-1:0] FAIL_ADDR
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                en_q, en_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ADDR_W:0]     err_q, err_d;
    logic [ADDR_W-1:0]   fail_q, fail_d;
    logic                chk_v_q, chk_v_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] s);
        return DATA_W'(a) + s;
    endfunction

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            seed_q     <= '0;
            din_q      <= '0;
            addr_q     <= '0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_q     <= '0;
            chk_v_q    <= 1'b0;
            exp_q      <= '0;
            cmp_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            din_q      <= din_d;
            addr_q     <= addr_d;
            en_q       <= en_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            fail_q     <= fail_d;
            chk_v_q    <= chk_v_d;
            exp_q      <= exp_d;
            cmp_addr_q <= cmp_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        din_d      = din_q;
        addr_d     = addr_q;
        en_d       = en_q;
        we_d       = we_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        fail_d     = fail_q;
        chk_v_d    = 1'b0;
        exp_d      = exp_q;
        cmp_addr_d = cmp_addr_q;

        // Read data for the word presented last cycle is on Dout now.
        if (chk_v_q && (Dout != exp_q)) begin
            err_d = err_q + (ADDR_W+1)'(1);
            if (err_q == '0) fail_d = cmp_addr_q;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                en_d = 1'b0;
                we_d = 1'b0;
                if (START) begin
                    seed_d  = SEED;
                    err_d   = '0;
                    fail_d  = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_WRITE;
                    addr_d  = '0;
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    din_d   = pattern('0, SEED);
                end
            end
            S_WRITE: begin
                if (addr_q == LAST) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    we_d    = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    din_d  = pattern(addr_q + ADDR_W'(1), seed_q);
                end
            end
            S_READ: begin
                chk_v_d    = 1'b1;
                exp_d      = pattern(addr_q, seed_q);
                cmp_addr_d = addr_q;
                if (addr_q == LAST) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                    en_d    = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                // err_d already includes the final word's compare.
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_d == '0);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Din       = din_q;
    assign Addr      = addr_q;
    assign EN        = en_q;
    assign WE        = we_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign ERR_CNT   = err_q;
    assign FAIL_ADDR = fail_q;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with LAST_ADDR=9 and a fault-injecting RAM model.
module tb_ram_bist;

    logic       CLK, RST, START;
    logic [7:0] SEED, Dout, Din, Addr, FAIL_ADDR;
    logic       EN, WE, BUSY, DONE, PASS;
    logic [8:0] ERR_CNT;

    logic [7:0]   mem [0:255];
    logic [255:0] fault_mask;
    logic [7:0]   wr_din [0:9];
    int           pass_cnt  = 0;
    int           total_cnt = 0;
    int           busy;

    ram_bist #(.DATA_W(8), .ADDR_W(8), .LAST_ADDR(9)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SEED(SEED), .Dout(Dout),
        .Din(Din), .Addr(Addr), .EN(EN), .WE(WE), .BUSY(BUSY), .DONE(DONE),
        .PASS(PASS), .ERR_CNT(ERR_CNT), .FAIL_ADDR(FAIL_ADDR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous RAM; masked addresses read back as 8'hFF.
    initial Dout = 8'h00;
    always @(posedge CLK) begin
        if (EN) begin
            if (WE) mem[Addr] <= Din;
            else    Dout <= fault_mask[Addr] ? 8'hFF : mem[Addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    endtask

    // One full test; checks the bus every cycle and optionally pulses START at pulse_cyc.
    task automatic run_bist(input logic [7:0] seed, input int pulse_cyc, output int busy_cycles);
        int cyc;
        @(negedge CLK); START = 1'b1; SEED = seed;
        @(negedge CLK); START = 1'b0;
        cyc = 0;
        while (BUSY && cyc < 100) begin
            if (cyc < 10) begin
                check("wr_addr", Addr, cyc);
                check("wr_en_we", {EN, WE}, 2'b11);
                wr_din[cyc] = Din;
            end else if (cyc < 20) begin
                check("rd_addr", Addr, cyc - 10);
                check("rd_en_we", {EN, WE}, 2'b10);
            end
            START = (cyc == pulse_cyc);
            cyc++;
            @(negedge CLK);
        end
        START = 1'b0;
        busy_cycles = cyc;
        $display("run seed=%02h busy=%0d err=%0d fail_addr=%0d pass=%0b done=%0b",
                 seed, cyc, ERR_CNT, FAIL_ADDR, PASS, DONE);
    endtask

    initial begin
        int n;
        RST = 1'b0; START = 1'b0; SEED = 8'h00; fault_mask = '0;
        repeat (2) @(negedge CLK);
        check("rst_ctrl", {EN, WE, BUSY, DONE, PASS}, 5'b0);
        check("rst_data", {Din, Addr, ERR_CNT, FAIL_ADDR}, 32'h0);
        RST = 1'b1;

        // Clean run, seed 01
        run_bist(8'h01, -1, busy);
        check("clean_busy", busy, 21);
        check("clean_din0", wr_din[0], 8'h01);
        check("clean_din9", wr_din[9], 8'h0A);
        for (int i = 0; i < 10; i++) check("clean_din", wr_din[i], i + 1);
        check("clean_res", {DONE, PASS, ERR_CNT}, {1'b1, 1'b1, 9'd0});

        // Single fault at address 5
        fault_mask[5] = 1'b1;
        run_bist(8'h01, -1, busy);
        check("f1_err", ERR_CNT, 1);
        check("f1_addr", FAIL_ADDR, 5);
        check("f1_done_pass", {DONE, PASS}, 2'b10);

        // Double fault, first address captured
        fault_mask = '0; fault_mask[3] = 1'b1; fault_mask[7] = 1'b1;
        run_bist(8'h01, -1, busy);
        check("f2_err", ERR_CNT, 2);
        check("f2_addr", FAIL_ADDR, 3);
        check("f2_pass", PASS, 0);

        // START in DONE clears previous results on the next edge
        fault_mask = '0;
        @(negedge CLK); START = 1'b1; SEED = 8'h01;
        @(negedge CLK); START = 1'b0;
        check("restart_err", ERR_CNT, 0);
        check("restart_addr", FAIL_ADDR, 0);
        check("restart_flags", {BUSY, DONE, PASS}, 3'b100);
        n = 0;
        while (BUSY && n < 100) begin @(negedge CLK); n++; end
        check("restart_busy", n, 21);
        check("restart_pass", PASS, 1);

        // Seed wrap
        run_bist(8'hFA, -1, busy);
        check("wrap_din0", wr_din[0], 8'hFA);
        check("wrap_din5", wr_din[5], 8'hFF);
        check("wrap_din6", wr_din[6], 8'h00);
        check("wrap_din9", wr_din[9], 8'h03);
        check("wrap_pass", {DONE, PASS, ERR_CNT}, {1'b1, 1'b1, 9'd0});

        // START during READ ignored
        run_bist(8'h5C, 13, busy);
        check("ign_busy", busy, 21);
        check("ign_pass", {DONE, PASS, ERR_CNT}, {1'b1, 1'b1, 9'd0});

        // Asynchronous reset during WRITE at Addr=4, with START asserted alongside
        @(negedge CLK); START = 1'b1; SEED = 8'h20;
        @(negedge CLK); START = 1'b0;
        n = 0;
        while (Addr != 8'd4 && n < 50) begin @(negedge CLK); n++; end
        check("mid_addr4", Addr, 4);
        check("mid_din4", Din, 8'h24);
        #2;
        SEED = 8'($urandom); START = 1'b1; RST = 1'b0;
        #1;
        check("mid_rst_ctrl", {EN, WE, BUSY, DONE, PASS}, 5'b0);
        check("mid_rst_data", {Din, Addr, ERR_CNT, FAIL_ADDR}, 32'h0);
        @(negedge CLK); START = 1'b0; RST = 1'b1;
        @(negedge CLK);
        check("post_rst_idle", {BUSY, EN}, 2'b00);

        run_bist(8'h37, -1, busy);
        check("post_busy", busy, 21);
        check("post_pass", {DONE, PASS, ERR_CNT}, {1'b1, 1'b1, 9'd0});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ram_bist.md
Name: ram_bist

Overview:
- Built-in self-test initiator for the single-port 8-bit synchronous RAM (ports Din, Addr, EN, WE, Dout).
- On a START pulse it does three things in order:
  - writes an address-derived pattern to every word from 0 to LAST_ADDR;
  - reads every word back;
  - compares each read against the expected value, counts mismatches and records the first failing address.
- Sits between the RAM and the lab top level or testbench; drives the RAM interface exclusively while BUSY.

Parameters:
- DATA_W, 8, RAM data width.
- ADDR_W, 8, RAM address width.
- LAST_ADDR, 255, highest address tested (0..LAST_ADDR); must be < 2^ADDR_W.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle start request.
- SEED  in  DATA_W  pattern offset; sampled on the accepted START.
- Dout  in  DATA_W  RAM read data; valid the cycle after a read is presented.
- Din  out  DATA_W  RAM write data.
- Addr  out  ADDR_W  RAM address.
- EN  out  1  RAM enable.
- WE  out  1  RAM write enable.
- BUSY  out  1  test in progress.
- DONE  out  1  test finished; held until next accepted START or reset.
- PASS  out  1  valid when DONE=1; high if ERR_CNT==0.
- ERR_CNT  out  ADDR_W+1  mismatch count.
- FAIL_ADDR  out  ADDR_W  address of first mismatch.

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE.
  - Din, Addr, EN, WE, BUSY, DONE, PASS, ERR_CNT, FAIL_ADDR are all 0; internal compare pipeline is cleared.
  - Applies immediately, including mid-test; EN and WE drop without waiting for a clock edge.
- All outputs are registered.
- Pattern: expected(a) = (a + seed_q) mod 2^DATA_W, where seed_q is the SEED value latched on START.
- States and transitions:
  - IDLE / DONE: EN=0, WE=0. START=1 at an edge does the following:
    - latches SEED;
    - clears ERR_CNT, FAIL_ADDR, DONE and PASS;
    - sets BUSY=1;
    - goes to WRITE with Addr=0.
  - WRITE: EN=1, WE=1, Din=expected(Addr), one word per cycle, Addr increments each cycle.
    - After the cycle presenting LAST_ADDR, goes to READ with Addr=0.
  - READ: EN=1, WE=0, one address per cycle.
    - Compare pipeline: chk_v <= 1, exp_q <= expected(Addr), addr_q <= Addr.
    - After LAST_ADDR, goes to DRAIN.
  - DRAIN: EN=0, WE=0. Lasts one cycle, during which the final word is compared. Then goes to DONE.
  - DONE: BUSY=0, DONE=1, PASS=(ERR_CNT==0).
- Compare step (every edge with chk_v=1):
  - Compares Dout against exp_q.
  - On mismatch: ERR_CNT increments.
  - If ERR_CNT was 0, FAIL_ADDR <= addr_q. Only the first failure is recorded.
- Read latency: Addr/EN driven in cycle n; RAM updates Dout at the end of n; BIST compares at the end of n+1.
- ERR_CNT width holds LAST_ADDR+1; no saturation is needed.
- START while BUSY=1 is ignored.
- START in DONE restarts the test.
- START and reset together: reset wins.
- Test duration: BUSY high for exactly 2*(LAST_ADDR+1)+1 cycles.
- Addr wrap: Addr never exceeds LAST_ADDR; the transition to READ reloads 0.

Test Plan:
- Reset defaults: assert RST=0 mid-clock with random inputs -> all outputs 0 immediately, before any clock edge.
- Clean run, LAST_ADDR=9, SEED=8'h01:
  - WRITE cycles show Addr 0..9 with Din 1..10, EN=1, WE=1.
  - READ cycles show Addr 0..9 with WE=0.
  - BUSY stays high 21 cycles; then DONE=1, PASS=1, ERR_CNT=0.
- Single fault, LAST_ADDR=9, SEED=8'h01:
  - Bench RAM model returns 8'hFF for the read of address 5.
  - Expect ERR_CNT=1, FAIL_ADDR=5, PASS=0, DONE=1.
- Double fault and first-address capture: corrupt reads at addresses 3 and 7 -> ERR_CNT=2, FAIL_ADDR=3, PASS=0.
- Seed wrap, SEED=8'hFA, LAST_ADDR=9:
  - Write Din at address 5 = 8'hFF, at 6 = 8'h00, at 9 = 8'h03.
  - Clean RAM gives PASS=1.
- Control corner cases:
  - START pulsed during READ is ignored; cycle count is unchanged.
  - RST=0 during WRITE at Addr=4 drops EN/WE/BUSY to 0 immediately.
  - After release, a new START runs full clean and gives PASS=1.
  - START in DONE clears the previous ERR_CNT/FAIL_ADDR on the next edge.
